// File: rtl/seq_detect_arb.sv
// Round-robin arbiter that lends one serial sequence detector to N_CH requesters:
// clears it, shifts the granted word in MSB-first and returns the match count.
module seq_detect_arb #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH*WIDTH-1:0]   word,
    output logic [N_CH-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [N_CH-1:0]         done_ch,
    output logic [CNT_W-1:0]        done_cnt,
    output logic                    det_din,
    output logic                    det_rst_n,
    input  logic                    det_flag
);

    localparam int unsigned PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [BIT_W-1:0]   bcnt_q, bcnt_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d, mcnt_inc;
    logic [N_CH-1:0]    gnt_d, done_ch_d;
    logic [CNT_W-1:0]   done_cnt_d;
    logic               busy_d, done_d, det_din_d, det_rst_n_d;
    logic               found;
    logic [PTR_W-1:0]   pick;

    // First requesting channel above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = ptr_q;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            idx = (32'(ptr_q) + i) % N_CH;
            if (!found && req[PTR_W'(idx)]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    assign mcnt_inc = (mcnt_q == CNT_MAX) ? mcnt_q : mcnt_q + 1'b1;

    // Next state plus the values every registered output takes next cycle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        sreg_d      = sreg_q;
        bcnt_d      = bcnt_q;
        mcnt_d      = mcnt_q;
        gnt_d       = '0;
        done_d      = 1'b0;
        done_ch_d   = '0;
        done_cnt_d  = '0;
        det_din_d   = 1'b0;
        det_rst_n_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d      = S_CLR;
                    sel_d        = pick;
                    ptr_d        = pick;
                    sreg_d       = word[32'(pick)*WIDTH +: WIDTH];
                    gnt_d[pick]  = 1'b1;
                    det_rst_n_d  = 1'b0;
                end
            end
            S_CLR: begin
                state_d   = S_SHIFT;
                mcnt_d    = '0;
                bcnt_d    = '0;
                det_din_d = sreg_q[WIDTH-1];
                sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
            end
            S_SHIFT: begin
                // The flag seen in the first shift cycle belongs to the cleared detector.
                if (bcnt_q != '0 && det_flag) begin
                    mcnt_d = mcnt_inc;
                end
                if (bcnt_q == BIT_W'(WIDTH - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    bcnt_d    = bcnt_q + 1'b1;
                    det_din_d = sreg_q[WIDTH-1];
                    sreg_d    = {sreg_q[WIDTH-2:0], 1'b0};
                end
            end
            S_DRAIN: begin
                state_d          = S_DONE;
                mcnt_d           = det_flag ? mcnt_inc : mcnt_q;
                done_d           = 1'b1;
                done_ch_d[sel_q] = 1'b1;
                done_cnt_d       = det_flag ? mcnt_inc : mcnt_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_W'(N_CH - 1);
            sel_q     <= '0;
            sreg_q    <= '0;
            bcnt_q    <= '0;
            mcnt_q    <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_ch   <= '0;
            done_cnt  <= '0;
            det_din   <= 1'b0;
            det_rst_n <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            sreg_q    <= sreg_d;
            bcnt_q    <= bcnt_d;
            mcnt_q    <= mcnt_d;
            gnt       <= gnt_d;
            busy      <= busy_d;
            done      <= done_d;
            done_ch   <= done_ch_d;
            done_cnt  <= done_cnt_d;
            det_din   <= det_din_d;
            det_rst_n <= det_rst_n_d;
        end
    end

endmodule
